axil_bram_ctrl: RTL and testbench

//  AXI4-Lite slave that terminates the S00_AXI port and drives a single-port synchronous BRAM.

---
 rtl/axil_bram_pkg.sv | 14 +
 rtl/axil_bram_ctrl.sv | 183 ++++++++++++++++++
 tb/tb_axil_bram_ctrl.sv | 403 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axil_bram_pkg.sv
// Shared FSM state type and AXI response codes for the AXI4-Lite BRAM controller.
package axil_bram_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WR_RESP = 2'd1,
        RD_WAIT = 2'd2,
        RD_DATA = 2'd3
    } axil_state_t;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

endpackage

// File: rtl/axil_bram_ctrl.sv
// AXI4-Lite slave that converts AW/W/B and AR/R traffic into single-port BRAM strobes.
// One transaction is in flight at a time; a read that arrives together with a write
// is parked and served in round-robin order.
module axil_bram_ctrl
    import axil_bram_pkg::*;
#(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 32,
    parameter int BRAM_ADDR_WIDTH    = 10
) (
    input  logic                              ACLK,
    input  logic                              ARESETN,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_AWADDR,
    input  logic [2:0]                        S_AXI_AWPROT,
    input  logic                              S_AXI_AWVALID,
    output logic                              S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   S_AXI_WSTRB,
    input  logic                              S_AXI_WVALID,
    output logic                              S_AXI_WREADY,
    output logic [1:0]                        S_AXI_BRESP,
    output logic                              S_AXI_BVALID,
    input  logic                              S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_ARADDR,
    input  logic [2:0]                        S_AXI_ARPROT,
    input  logic                              S_AXI_ARVALID,
    output logic                              S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_RDATA,
    output logic [1:0]                        S_AXI_RRESP,
    output logic                              S_AXI_RVALID,
    input  logic                              S_AXI_RREADY,
    output logic                              bram_en,
    output logic [C_S_AXI_DATA_WIDTH/8-1:0]   bram_we,
    output logic [BRAM_ADDR_WIDTH-1:0]        bram_addr,
    output logic [C_S_AXI_DATA_WIDTH-1:0]     bram_wdata,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]     bram_rdata
);

    localparam int AW     = C_S_AXI_ADDR_WIDTH;
    localparam int DW     = C_S_AXI_DATA_WIDTH;
    localparam int SW     = DW / 8;
    localparam int WORD_H = BRAM_ADDR_WIDTH + 2;

    // Any byte-address bit above the BRAM word field selects a location that does not exist.
    function automatic logic out_of_range(input logic [AW-1:0] addr);
        return |addr[AW-1:WORD_H];
    endfunction

    axil_state_t     state_q, state_d;
    logic            aw_held_q, w_held_q, ar_held_q;
    logic            aw_held_d, w_held_d, ar_held_d;
    logic [AW-1:0]   aw_addr_q, ar_addr_q, rd_addr;
    logic [DW-1:0]   w_data_q;
    logic [SW-1:0]   w_strb_q;
    logic            rd_prio_q;   // last served was a write, so a contending read wins next
    logic            rd_oor_q;
    logic            aw_hs, w_hs, ar_hs, b_hs, r_hs;
    logic            wr_rdy, wr_soon, rd_pend, write_go, read_go;
    logic            unused_bits;

    assign aw_hs = S_AXI_AWVALID && S_AXI_AWREADY;
    assign w_hs  = S_AXI_WVALID  && S_AXI_WREADY;
    assign ar_hs = S_AXI_ARVALID && S_AXI_ARREADY;
    assign b_hs  = S_AXI_BVALID  && S_AXI_BREADY;
    assign r_hs  = S_AXI_RVALID  && S_AXI_RREADY;

    // A write is ready once both halves are held; wr_soon flags the cycle both halves complete.
    assign wr_rdy   = aw_held_q && w_held_q;
    assign wr_soon  = !wr_rdy && (aw_held_q || aw_hs) && (w_held_q || w_hs);
    assign rd_pend  = ar_held_q || ar_hs;
    assign rd_addr  = ar_held_q ? ar_addr_q : S_AXI_ARADDR;
    assign write_go = (state_q == IDLE) && wr_rdy && !(rd_pend && rd_prio_q);
    assign read_go  = (state_q == IDLE) && rd_pend && !((wr_rdy || wr_soon) && !rd_prio_q);

    assign unused_bits = ^{S_AXI_AWPROT, S_AXI_ARPROT, aw_addr_q[1:0], rd_addr[1:0]};

    // State register.
    always_ff @(posedge ACLK) begin
        // NOTE: non-blocking assignments in clocked blocks so every register samples pre-edge values.
        if (!ARESETN) state_q <= IDLE;
        else          state_q <= state_d;
    end

    // Next state, BRAM strobes and next values of the holding flags.
    always_comb begin
        // NOTE: every output gets a default first so no branch can leave it unassigned (no latch).
        state_d    = state_q;
        bram_en    = 1'b0;
        bram_we    = '0;
        bram_addr  = '0;
        bram_wdata = w_data_q;
        aw_held_d  = aw_held_q || aw_hs;
        w_held_d   = w_held_q  || w_hs;
        ar_held_d  = ar_held_q;
        unique case (state_q)
            IDLE: begin
                if (write_go) begin
                    state_d   = WR_RESP;
                    bram_en   = !out_of_range(aw_addr_q);
                    bram_we   = out_of_range(aw_addr_q) ? '0 : w_strb_q;
                    bram_addr = aw_addr_q[WORD_H-1:2];
                end else if (read_go) begin
                    state_d   = RD_WAIT;
                    bram_en   = !out_of_range(rd_addr);
                    bram_addr = rd_addr[WORD_H-1:2];
                end
                if (read_go)    ar_held_d = 1'b0;
                else if (ar_hs) ar_held_d = 1'b1;
            end
            WR_RESP: begin
                if (b_hs) begin
                    state_d   = IDLE;
                    aw_held_d = 1'b0;
                    w_held_d  = 1'b0;
                end
            end
            RD_WAIT: state_d = RD_DATA;
            RD_DATA: if (r_hs) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Holding flags, arbitration history and registered READY outputs.
    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            aw_held_q     <= 1'b0;
            w_held_q      <= 1'b0;
            ar_held_q     <= 1'b0;
            rd_prio_q     <= 1'b0;
            S_AXI_AWREADY <= 1'b0;
            S_AXI_WREADY  <= 1'b0;
            S_AXI_ARREADY <= 1'b0;
        end else begin
            aw_held_q     <= aw_held_d;
            w_held_q      <= w_held_d;
            ar_held_q     <= ar_held_d;
            if (write_go)     rd_prio_q <= 1'b1;
            else if (read_go) rd_prio_q <= 1'b0;
            S_AXI_AWREADY <= (state_d == IDLE) && !aw_held_d;
            S_AXI_WREADY  <= (state_d == IDLE) && !w_held_d;
            S_AXI_ARREADY <= (state_d == IDLE) && !ar_held_d;
        end
    end

    // Address and data payload capture on each handshake.
    always_ff @(posedge ACLK) begin
        // NOTE: payload registers carry no reset; the held flags say when they are meaningful.
        if (aw_hs) aw_addr_q <= S_AXI_AWADDR;
        if (ar_hs) ar_addr_q <= S_AXI_ARADDR;
        if (w_hs) begin
            w_data_q <= S_AXI_WDATA;
            w_strb_q <= S_AXI_WSTRB;
        end
    end

    // B and R channel response registers; held stable until their handshake.
    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            S_AXI_BVALID <= 1'b0;
            S_AXI_BRESP  <= RESP_OKAY;
            S_AXI_RVALID <= 1'b0;
            S_AXI_RRESP  <= RESP_OKAY;
            S_AXI_RDATA  <= '0;
            rd_oor_q     <= 1'b0;
        end else begin
            if (write_go) begin
                S_AXI_BVALID <= 1'b1;
                S_AXI_BRESP  <= out_of_range(aw_addr_q) ? RESP_SLVERR : RESP_OKAY;
            end else if (b_hs) begin
                S_AXI_BVALID <= 1'b0;
            end
            if (read_go) rd_oor_q <= out_of_range(rd_addr);
            if (state_q == RD_WAIT) begin
                S_AXI_RVALID <= 1'b1;
                S_AXI_RDATA  <= rd_oor_q ? '0 : bram_rdata;
                S_AXI_RRESP  <= rd_oor_q ? RESP_SLVERR : RESP_OKAY;
            end else if (r_hs) begin
                S_AXI_RVALID <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_axil_bram_ctrl.sv
// Directed testbench for axil_bram_ctrl with a behavioural 1-cycle BRAM.
module tb_axil_bram_ctrl;
    import axil_bram_pkg::*;

    localparam int MAX_WAIT = 40;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic [31:0] awaddr = '0, wdata = '0, araddr = '0;
    logic [3:0]  wstrb = '0;
    logic        awvalid = 1'b0, wvalid = 1'b0, bready = 1'b0, arvalid = 1'b0, rready = 1'b0;
    logic [2:0]  awprot = 3'b000, arprot = 3'b000;
    logic        awready, wready, bvalid, arready, rvalid;
    logic [1:0]  bresp, rresp;
    logic [31:0] rdata;
    logic        bram_en;
    logic [3:0]  bram_we;
    logic [9:0]  bram_addr;
    logic [31:0] bram_wdata, bram_rdata;
    logic [31:0] mem [1024];

    int checks = 0;
    int errors = 0;
    int en_cnt = 0;
    int we_cnt = 0;

    always #5 clk = ~clk;

    axil_bram_ctrl dut (
        .ACLK(clk), .ARESETN(rstn),
        .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(awprot), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
        .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
        .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
        .S_AXI_ARADDR(araddr), .S_AXI_ARPROT(arprot), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
        .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
        .bram_en(bram_en), .bram_we(bram_we), .bram_addr(bram_addr),
        .bram_wdata(bram_wdata), .bram_rdata(bram_rdata)
    );

    // Behavioural single-port BRAM with byte enables and 1-cycle read latency.
    initial for (int i = 0; i < 1024; i++) mem[i] = '0;
    always @(posedge clk) begin
        if (bram_en) begin
            for (int b = 0; b < 4; b++)
                if (bram_we[b]) mem[bram_addr][8*b +: 8] <= bram_wdata[8*b +: 8];
            bram_rdata <= mem[bram_addr];
        end
    end

    // Strobe counters sampled mid-cycle, well away from both clock edges.
    always @(negedge clk) begin
        #2;
        if (bram_en) begin
            en_cnt++;
            if (|bram_we) we_cnt++;
        end
    end

    task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                            output logic [1:0] resp);
        logic aw_done, w_done, b_done;
        aw_done = 1'b0; w_done = 1'b0; b_done = 1'b0; resp = 2'b11;
        @(negedge clk);
        awaddr = a; awvalid = 1'b1; wdata = d; wstrb = s; wvalid = 1'b1;
        #1;
        for (int i = 0; i < MAX_WAIT; i++) begin
            if (awvalid && awready) aw_done = 1'b1;
            if (wvalid && wready)   w_done  = 1'b1;
            @(negedge clk);
            if (aw_done) awvalid = 1'b0;
            if (w_done)  wvalid  = 1'b0;
            #1;
            if (aw_done && w_done) break;
        end
        bready = 1'b1;
        for (int i = 0; i < MAX_WAIT; i++) begin
            if (bvalid) begin resp = bresp; b_done = 1'b1; end
            @(negedge clk);
            if (b_done) bready = 1'b0;
            #1;
            if (b_done) break;
        end
        awvalid = 1'b0; wvalid = 1'b0; bready = 1'b0;
        checks++;
        if (!(aw_done && w_done && b_done)) begin
            errors++;
            $display("FAIL write_timeout addr=%h: aw=%0b w=%0b b=%0b, required all 1", a, aw_done, w_done, b_done);
        end
    endtask

    task automatic do_read(input logic [31:0] a, output logic [31:0] d, output logic [1:0] resp);
        logic ar_done, r_done;
        ar_done = 1'b0; r_done = 1'b0; d = '0; resp = 2'b11;
        @(negedge clk);
        araddr = a; arvalid = 1'b1;
        #1;
        for (int i = 0; i < MAX_WAIT; i++) begin
            if (arvalid && arready) ar_done = 1'b1;
            @(negedge clk);
            if (ar_done) arvalid = 1'b0;
            #1;
            if (ar_done) break;
        end
        rready = 1'b1;
        for (int i = 0; i < MAX_WAIT; i++) begin
            if (rvalid) begin d = rdata; resp = rresp; r_done = 1'b1; end
            @(negedge clk);
            if (r_done) rready = 1'b0;
            #1;
            if (r_done) break;
        end
        arvalid = 1'b0; rready = 1'b0;
        checks++;
        if (!(ar_done && r_done)) begin
            errors++;
            $display("FAIL read_timeout addr=%h: ar=%0b r=%0b, required both 1", a, ar_done, r_done);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if ({awready, wready, arready, bvalid, rvalid, bram_en} !== 6'b0) begin
            errors++;
            $display("FAIL reset_ctrl: {awr,wr,arr,bv,rv,en}=%b, required 000000",
                     {awready, wready, arready, bvalid, rvalid, bram_en});
        end
        checks++;
        if ({bresp, rresp, rdata, bram_we} !== 40'h0) begin
            errors++;
            $display("FAIL reset_data: bresp=%b rresp=%b rdata=%h we=%b, required all 0", bresp, rresp, rdata, bram_we);
        end
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        #1;
        checks++;
        if ({awready, wready, arready} !== 3'b111) begin
            errors++;
            $display("FAIL reset_release_ready: {awr,wr,arr}=%b, required 111", {awready, wready, arready});
        end
    endtask

    task automatic test_basic();
        logic [1:0]  r;
        logic [31:0] d;
        for (int i = 0; i < 4; i++) begin
            do_write(32'(i * 4), 32'(i + 1), 4'hF, r);
            checks++;
            if (r !== RESP_OKAY) begin
                errors++; $display("FAIL basic_bresp[%0d]: got %b, required %b", i, r, RESP_OKAY);
            end
        end
        for (int i = 0; i < 4; i++) begin
            do_read(32'(i * 4), d, r);
            checks++;
            if (d !== 32'(i + 1) || r !== RESP_OKAY) begin
                errors++; $display("FAIL basic_read[%0d]: got %h/%b, required %h/%b", i, d, r, 32'(i + 1), RESP_OKAY);
            end
        end
    endtask

    task automatic test_strobe();
        logic [1:0]  r;
        logic [31:0] d;
        do_write(32'h10, 32'hAABBCCDD, 4'hF, r);
        do_write(32'h10, 32'h11223344, 4'b0101, r);
        do_read(32'h10, d, r);
        checks++;
        if (d !== 32'hAA22CC44) begin
            errors++; $display("FAIL strobe_merge: got %h, required aa22cc44", d);
        end
    endtask

    // Drives the early channel, waits three cycles, then the late one; checks strobe and BVALID timing.
    task automatic skewed_write(input logic aw_first, input logic [31:0] a, input logic [31:0] d);
        int we0;
        we0 = we_cnt;
        @(negedge clk);
        if (aw_first) begin awaddr = a; awvalid = 1'b1; end
        else          begin wdata = d; wstrb = 4'hF; wvalid = 1'b1; end
        @(negedge clk);
        awvalid = 1'b0; wvalid = 1'b0;
        #1;
        checks++;
        if ({awready, wready} !== (aw_first ? 2'b01 : 2'b10)) begin
            errors++; $display("FAIL skew_ready aw_first=%0b: {awr,wr}=%b, required %b",
                               aw_first, {awready, wready}, aw_first ? 2'b01 : 2'b10);
        end
        repeat (2) @(negedge clk);
        if (aw_first) begin wdata = d; wstrb = 4'hF; wvalid = 1'b1; end
        else          begin awaddr = a; awvalid = 1'b1; end
        @(negedge clk);
        awvalid = 1'b0; wvalid = 1'b0;
        #1;
        checks++;
        if ({bram_en, bram_we, bvalid} !== 6'b1_1111_0) begin
            errors++; $display("FAIL skew_strobe aw_first=%0b: en=%b we=%b bvalid=%b, required 1/1111/0",
                               aw_first, bram_en, bram_we, bvalid);
        end
        @(negedge clk);
        #1;
        checks++;
        if ({bvalid, bram_we} !== 5'b1_0000) begin
            errors++; $display("FAIL skew_bvalid aw_first=%0b: bvalid=%b we=%b, required 1/0000", aw_first, bvalid, bram_we);
        end
        bready = 1'b1;
        @(negedge clk);
        bready = 1'b0;
        #1;
        checks++;
        if (bvalid !== 1'b0 || we_cnt - we0 !== 1) begin
            errors++; $display("FAIL skew_pulses aw_first=%0b: bvalid=%b pulses=%0d, required 0/1",
                               aw_first, bvalid, we_cnt - we0);
        end
    endtask

    task automatic test_skew();
        logic [1:0]  r;
        logic [31:0] d;
        skewed_write(1'b1, 32'h14, 32'h0BADCAFE);
        skewed_write(1'b0, 32'h18, 32'h600DD00D);
        do_read(32'h14, d, r);
        checks++;
        if (d !== 32'h0BADCAFE) begin errors++; $display("FAIL skew_read14: got %h, required 0badcafe", d); end
        do_read(32'h18, d, r);
        checks++;
        if (d !== 32'h600DD00D) begin errors++; $display("FAIL skew_read18: got %h, required 600dd00d", d); end
    endtask

    task automatic test_stall();
        logic got;
        @(negedge clk);
        awaddr = 32'h24; awvalid = 1'b1; wdata = 32'hCAFEF00D; wstrb = 4'hF; wvalid = 1'b1;
        @(negedge clk);
        awvalid = 1'b0; wvalid = 1'b0;
        @(negedge clk);
        araddr = 32'h24; arvalid = 1'b1;
        #1;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if ({bvalid, bresp, awready, wready, arready} !== 6'b1_00_000) begin
                errors++; $display("FAIL stall_b[%0d]: bvalid=%b bresp=%b ready=%b, required 1/00/000",
                                   i, bvalid, bresp, {awready, wready, arready});
            end
            @(negedge clk);
            #1;
        end
        bready = 1'b1;
        @(negedge clk);
        bready = 1'b0;
        #1;
        checks++;
        if (bvalid !== 1'b0) begin errors++; $display("FAIL stall_b_release: bvalid=%b, required 0", bvalid); end
        got = 1'b0;
        for (int i = 0; i < MAX_WAIT; i++) begin
            if (arvalid && arready) got = 1'b1;
            @(negedge clk);
            if (got) arvalid = 1'b0;
            #1;
            if (got && rvalid) break;
        end
        checks++;
        if (!(got && rvalid)) begin errors++; $display("FAIL stall_r_timeout: ar=%b rvalid=%b, required 1/1", got, rvalid); end
        for (int i = 0; i < 5; i++) begin
            checks++;
            if ({rvalid, rresp, awready, wready, arready} !== 6'b1_00_000 || rdata !== 32'hCAFEF00D) begin
                errors++; $display("FAIL stall_r[%0d]: rvalid=%b rresp=%b ready=%b rdata=%h, required 1/00/000/cafef00d",
                                   i, rvalid, rresp, {awready, wready, arready}, rdata);
            end
            @(negedge clk);
            #1;
        end
        rready = 1'b1;
        @(negedge clk);
        rready = 1'b0;
        #1;
        checks++;
        if (rvalid !== 1'b0) begin errors++; $display("FAIL stall_r_release: rvalid=%b, required 0", rvalid); end
    endtask

    // AW, W and AR in the same cycle; records which BRAM strobe comes first.
    task automatic contend(input logic [31:0] a, input logic [31:0] d, input logic exp_wr_first,
                           input logic [31:0] exp_rd);
        logic aw_done, w_done, ar_done, b_done, r_done;
        int first;   // 0 none, 1 write strobe, 2 read strobe
        logic [31:0] got_d;
        aw_done = 0; w_done = 0; ar_done = 0; b_done = 0; r_done = 0; first = 0; got_d = '0;
        @(negedge clk);
        awaddr = a; awvalid = 1'b1; wdata = d; wstrb = 4'hF; wvalid = 1'b1;
        araddr = a; arvalid = 1'b1; bready = 1'b1; rready = 1'b1;
        #1;
        for (int i = 0; i < MAX_WAIT; i++) begin
            if (bram_en && first == 0) first = (|bram_we) ? 1 : 2;
            if (awvalid && awready) aw_done = 1'b1;
            if (wvalid && wready)   w_done  = 1'b1;
            if (arvalid && arready) ar_done = 1'b1;
            if (bvalid) b_done = 1'b1;
            if (rvalid) begin r_done = 1'b1; got_d = rdata; end
            @(negedge clk);
            if (aw_done) awvalid = 1'b0;
            if (w_done)  wvalid  = 1'b0;
            if (ar_done) arvalid = 1'b0;
            if (b_done)  bready  = 1'b0;
            if (r_done)  rready  = 1'b0;
            #1;
            if (b_done && r_done) break;
        end
        awvalid = 0; wvalid = 0; arvalid = 0; bready = 0; rready = 0;
        checks++;
        if (first !== (exp_wr_first ? 1 : 2) || !(b_done && r_done)) begin
            errors++; $display("FAIL arb_order addr=%h: first=%0d b=%0b r=%0b, required first=%0d b=1 r=1",
                               a, first, b_done, r_done, exp_wr_first ? 1 : 2);
        end
        checks++;
        if (got_d !== exp_rd) begin
            errors++; $display("FAIL arb_data addr=%h: got %h, required %h", a, got_d, exp_rd);
        end
    endtask

    task automatic test_arbitration();
        logic [1:0]  r;
        logic [31:0] d;
        do_write(32'h30, 32'h55, 4'hF, r);
        do_read(32'h30, d, r);
        contend(32'h30, 32'h66, 1'b1, 32'h66);
        contend(32'h30, 32'h77, 1'b1, 32'h77);
        do_write(32'h34, 32'h88, 4'hF, r);
        contend(32'h34, 32'h99, 1'b0, 32'h88);
        do_read(32'h34, d, r);
        checks++;
        if (d !== 32'h99) begin errors++; $display("FAIL arb_final: got %h, required 00000099", d); end
    endtask

    task automatic test_out_of_range();
        logic [1:0]  r;
        logic [31:0] d;
        int e0;
        e0 = en_cnt;
        do_write(32'h1000, 32'hDEADBEEF, 4'hF, r);
        checks++;
        if (r !== RESP_SLVERR) begin errors++; $display("FAIL oor_bresp: got %b, required 10", r); end
        do_read(32'h1000, d, r);
        checks++;
        if (r !== RESP_SLVERR || d !== 32'h0) begin
            errors++; $display("FAIL oor_read: got %h/%b, required 00000000/10", d, r);
        end
        checks++;
        if (en_cnt !== e0) begin errors++; $display("FAIL oor_no_en: en pulses=%0d, required 0", en_cnt - e0); end
        do_read(32'h0, d, r);
        checks++;
        if (d !== 32'h1 || r !== RESP_OKAY) begin
            errors++; $display("FAIL oor_alias: word0=%h/%b, required 00000001/00", d, r);
        end
    endtask

    task automatic test_reset_rd_wait();
        @(negedge clk);
        araddr = 32'h4; arvalid = 1'b1;
        @(negedge clk);
        arvalid = 1'b0;
        #1;
        checks++;
        if (dut.state_q !== RD_WAIT) begin
            errors++; $display("FAIL rdwait_entry: state=%0d, required %0d", dut.state_q, RD_WAIT);
        end
        rstn = 1'b0;
        @(negedge clk);
        #1;
        checks++;
        if (rvalid !== 1'b0 || dut.state_q !== IDLE) begin
            errors++; $display("FAIL rdwait_reset: rvalid=%b state=%0d, required 0/%0d", rvalid, dut.state_q, IDLE);
        end
        rstn = 1'b1;
        @(negedge clk);
        #1;
        checks++;
        if (rvalid !== 1'b0 || arready !== 1'b1) begin
            errors++; $display("FAIL rdwait_recover: rvalid=%b arready=%b, required 0/1", rvalid, arready);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_strobe();
        test_skew();
        test_stall();
        test_arbitration();
        test_out_of_range();
        test_reset_rd_wait();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
